// File: rtl/seq_divider_128by64_pkg.sv
// Shared types and defaults for the 128/64 sequential restoring divider.
// FSM encodings match the multiplier-side arithmetic unit (IDLE=0, BUSY=1, DONE=2).
package seq_divider_128by64_pkg;

    localparam int DIV_WIDTH = 64;
    localparam int DIV_CNT_W = 7;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/seq_divider_128by64_if.sv
// Operand/result handshake bundle for the sequential divider.
// master = operand producer / result consumer, slave = the divider.
interface seq_divider_128by64_if
    import seq_divider_128by64_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic                 in_valid;
    logic                 in_ready;
    logic [2*WIDTH-1:0]   dividend;
    logic [WIDTH-1:0]     divisor;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDTH-1:0]     quotient;
    logic [WIDTH-1:0]     remainder;
    logic                 div_zero;
    logic                 overflow;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_zero, overflow
    );

endinterface

// File: rtl/seq_divider_128by64_div_step.sv
// One restoring-division step: trial subtract of the divisor from the shifted
// partial remainder, keeping the difference only when it does not go negative.
module seq_divider_128by64_div_step
    import seq_divider_128by64_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH-1:0] rem,
    input  logic             q_msb,
    input  logic [WIDTH-1:0] dsr,
    output logic [WIDTH-1:0] rem_next,
    output logic             q_bit
);

    logic [WIDTH:0] trial;

    // rem < dsr keeps {rem,q_msb} < 2*dsr, so W+1 bits hold the sign cleanly
    always_comb begin
        trial    = {rem, q_msb} - {1'b0, dsr};
        q_bit    = ~trial[WIDTH];
        rem_next = q_bit ? trial[WIDTH-1:0] : {rem[WIDTH-2:0], q_msb};
    end

endmodule

// File: rtl/seq_divider_128by64.sv
// Iterative radix-2 restoring divider, 2W-bit dividend / W-bit divisor.
// Define DIV_EARLY_OUT_EN to send overflow/divide-by-zero ops straight to DONE.
//
// state    | meaning
// DIV_IDLE | in_ready high, waiting for operands
// DIV_BUSY | one quotient bit per clock, counter WIDTH-1 down to 0
// DIV_DONE | result held on outputs until out_ready
module seq_divider_128by64
    import seq_divider_128by64_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = DIV_CNT_W
) (
    input  logic                  clk,
    input  logic                  rst_n,
    seq_divider_128by64_if.slave  bus
);

    div_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [WIDTH-1:0]  rem;
    logic [WIDTH-1:0]  q;
    logic [WIDTH-1:0]  dsr;
    logic [WIDTH-1:0]  lo_hold;
    logic              ovf_r;
    logic              dz_r;

    logic              in_ready_r;
    logic              out_valid_r;
    logic [WIDTH-1:0]  quotient_r;
    logic [WIDTH-1:0]  remainder_r;
    logic              div_zero_r;
    logic              overflow_r;

    logic [WIDTH-1:0]  hi_in;
    logic [WIDTH-1:0]  lo_in;
    logic              ovf_in;
    logic              dz_in;
    logic [WIDTH-1:0]  rem_next;
    logic              q_bit;

    assign hi_in  = bus.dividend[2*WIDTH-1:WIDTH];
    assign lo_in  = bus.dividend[WIDTH-1:0];
    // a zero divisor always satisfies hi >= divisor, so overflow also flags it
    assign ovf_in = (hi_in >= bus.divisor);
    assign dz_in  = (bus.divisor == '0);

    seq_divider_128by64_div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem),
        .q_msb    (q[WIDTH-1]),
        .dsr      (dsr),
        .rem_next (rem_next),
        .q_bit    (q_bit)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= DIV_IDLE;
            cnt         <= '0;
            rem         <= '0;
            q           <= '0;
            dsr         <= '0;
            lo_hold     <= '0;
            ovf_r       <= 1'b0;
            dz_r        <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            quotient_r  <= '0;
            remainder_r <= '0;
            div_zero_r  <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            case (state)
                DIV_IDLE: begin
                    if (bus.in_valid) begin
                        rem        <= hi_in;
                        q          <= lo_in;
                        dsr        <= bus.divisor;
                        lo_hold    <= lo_in;
                        cnt        <= CNT_W'(WIDTH - 1);
                        ovf_r      <= ovf_in;
                        dz_r       <= dz_in;
                        in_ready_r <= 1'b0;
`ifdef DIV_EARLY_OUT_EN
                        if (ovf_in) begin
                            state       <= DIV_DONE;
                            out_valid_r <= 1'b1;
                            quotient_r  <= '1;
                            remainder_r <= lo_in;
                            overflow_r  <= 1'b1;
                            div_zero_r  <= dz_in;
                        end else begin
                            state <= DIV_BUSY;
                        end
`else
                        state      <= DIV_BUSY;
`endif
                    end
                end
                DIV_BUSY: begin
                    rem <= rem_next;
                    q   <= {q[WIDTH-2:0], q_bit};
                    if (cnt == '0) begin
                        state       <= DIV_DONE;
                        out_valid_r <= 1'b1;
                        overflow_r  <= ovf_r;
                        div_zero_r  <= dz_r;
                        if (ovf_r) begin
                            quotient_r  <= '1;
                            remainder_r <= lo_hold;
                        end else begin
                            quotient_r  <= {q[WIDTH-2:0], q_bit};
                            remainder_r <= rem_next;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                DIV_DONE: begin
                    if (bus.out_ready) begin
                        state       <= DIV_IDLE;
                        in_ready_r  <= 1'b1;
                        out_valid_r <= 1'b0;
                        quotient_r  <= '0;
                        remainder_r <= '0;
                        div_zero_r  <= 1'b0;
                        overflow_r  <= 1'b0;
                    end
                end
                default: begin
                    state       <= DIV_IDLE;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.div_zero  = div_zero_r;
    assign bus.overflow  = overflow_r;

endmodule

// File: tb/tb_seq_divider_128by64.sv
// Randomized self-checking bench for seq_divider_128by64 against a plain
// 128-bit arithmetic reference; honours DIV_EARLY_OUT_EN for latency.
module tb_seq_divider_128by64;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    seq_divider_128by64_if #(.WIDTH(64)) bus ();

    seq_divider_128by64 #(.WIDTH(64), .CNT_W(7)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: exact integer division, forced result when quotient cannot fit
    task automatic ref_div(input logic [127:0] dd, input logic [63:0] ds,
                           output logic [63:0] q, output logic [63:0] r,
                           output logic dz, output logic ovf, output int lat);
        logic [127:0] qq;
        logic [127:0] rr;
        dz  = (ds == 64'd0);
        ovf = dz || (dd[127:64] >= ds);
        lat = 65;
        if (ovf) begin
            q = '1;
            r = dd[63:0];
`ifdef DIV_EARLY_OUT_EN
            lat = 1;
`endif
        end else begin
            qq = dd / {64'd0, ds};
            rr = dd % {64'd0, ds};
            q  = qq[63:0];
            r  = rr[63:0];
        end
    endtask

    task automatic accept_op(input logic [127:0] dd, input logic [63:0] ds);
        int waited;
        bus.in_valid = 1'b1;
        bus.dividend = dd;
        bus.divisor  = ds;
        waited = 0;
        while (!bus.in_ready && waited < 200) begin
            @(posedge clk);
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) chk("accept_wait", {127'd0, bus.in_ready}, 128'd1);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.dividend = {$urandom, $urandom, $urandom, $urandom};
        bus.divisor  = {$urandom, $urandom};
    endtask

    task automatic run_op(input string name, input logic [127:0] dd, input logic [63:0] ds,
                          input int stall);
        logic [63:0] eq;
        logic [63:0] er;
        logic        edz;
        logic        eovf;
        int          elat;
        int          lat;
        ref_div(dd, ds, eq, er, edz, eovf, elat);
        accept_op(dd, ds);
        lat = 1;
        if (!bus.out_valid) chk({name, ".busy_in_ready"}, {127'd0, bus.in_ready}, 128'd0);
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        chk({name, ".latency"}, lat, elat);
        chk({name, ".quotient"}, bus.quotient, eq);
        chk({name, ".remainder"}, bus.remainder, er);
        chk({name, ".div_zero"}, {127'd0, bus.div_zero}, {127'd0, edz});
        chk({name, ".overflow"}, {127'd0, bus.overflow}, {127'd0, eovf});
        for (int i = 0; i < stall; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk({name, ".stall_q"}, bus.quotient, eq);
            chk({name, ".stall_r"}, bus.remainder, er);
            chk({name, ".stall_valid"}, {127'd0, bus.out_valid}, 128'd1);
            chk({name, ".stall_in_ready"}, {127'd0, bus.in_ready}, 128'd0);
            chk({name, ".stall_flags"}, {126'd0, bus.overflow, bus.div_zero}, {126'd0, eovf, edz});
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk({name, ".release_valid"}, {127'd0, bus.out_valid}, 128'd0);
        chk({name, ".release_in_ready"}, {127'd0, bus.in_ready}, 128'd1);
        chk({name, ".release_q"}, bus.quotient, 128'd0);
    endtask

    initial begin
        logic [127:0] dd;
        logic [63:0]  ds;
        n_checks      = 0;
        n_errors      = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst.in_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("rst.out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("rst.quotient", bus.quotient, 128'd0);
        chk("rst.remainder", bus.remainder, 128'd0);
        chk("rst.flags", {126'd0, bus.overflow, bus.div_zero}, 128'd0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("t1_100div7", 128'd100, 64'd7, 0);
        run_op("t2_max_sq", 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        run_op("t3_divzero", 128'h5, 64'd0, 0);
        run_op("t4_overflow", 128'h0000_0000_0000_0003_0000_0000_0000_0000, 64'd3, 0);
        run_op("t5_stall", 128'h1234_5678_9ABC_DEF0_1111_2222_3333_4444, 64'hFEDC_BA98_7654_3210, 10);

        // reset in the middle of an iteration run
        accept_op(128'h0000_0000_0000_0001_0000_0000_0000_0000, 64'd12345);
        repeat (29) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6.rst_in_ready", {127'd0, bus.in_ready}, 128'd1);
        chk("t6.rst_out_valid", {127'd0, bus.out_valid}, 128'd0);
        chk("t6.rst_outputs", {bus.quotient, bus.remainder}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("t6_1000div10", 128'd1000, 64'd10, 0);

        for (int n = 0; n < 24; n++) begin
            ds = {$urandom, $urandom} >> $urandom_range(0, 63);
            if ($urandom_range(0, 5) == 0) ds = 64'd0;
            dd[63:0] = {$urandom, $urandom};
            if (ds != 0 && $urandom_range(0, 3) != 0)
                dd[127:64] = {$urandom, $urandom} % ds;
            else
                dd[127:64] = {$urandom, $urandom};
            run_op("rand", dd, ds, $urandom_range(0, 3));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
